// File: rtl/codec_cfg_pkg.sv
// Shared constants for the codec configuration sequencer: state codes, I2C frame shape, tick divider.
package codec_cfg_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_START = 3'd2;
  localparam state_t ST_BITS  = 3'd3;
  localparam state_t ST_STOP  = 3'd4;
  localparam state_t ST_GAP   = 3'd5;
  localparam state_t ST_DONE  = 3'd6;
  localparam state_t ST_ERR   = 3'd7;

  localparam int FRAME_BITS    = 27;
  localparam int ACK_SLOT0     = 8;
  localparam int ACK_SLOT1     = 17;
  localparam int ACK_SLOT2     = 26;
  localparam int TICKS_PER_BIT = 4;
  localparam int GAP_TICKS     = 4;

  function automatic int tick_div(input int clk_hz, input int scl_hz);
    return clk_hz / (4 * scl_hz);
  endfunction

endpackage

// File: rtl/i2c_write_engine.sv
// Single 3-byte I2C write: tick divider, START, 27 bit slots with ACK sampling, STOP and bus-free gap.
// Requires DIV >= 2 so the one-clock LOAD between frames never coincides with a tick.
module i2c_write_engine
  import codec_cfg_pkg::*;
#(
  parameter int DIV = 125
) (
  input  logic        i_CLK,
  input  logic        i_NRESET,
  input  logic        run,
  input  logic        go,
  input  logic [23:0] frame,
  input  logic        sda_in,
  output logic        scl,
  output logic        sda_oe,
  output logic        done,
  output logic        nack
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          tick;
  logic          active;
  state_t        phase;
  logic [1:0]    q;
  logic [4:0]    slot;
  logic [23:0]   sr;
  logic          fail;
  logic          is_ack;
  logic          q_last;
  logic          scl_d;
  logic          oe_d;

  // Divider keeps running across LOAD so frames stay on one tick grid.
  assign tick = run && (div_cnt == CW'(DIV - 1));

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET)         div_cnt <= '0;
    else if (!run || tick) div_cnt <= '0;
    else                   div_cnt <= div_cnt + 1'b1;
  end

  assign is_ack = (slot == 5'(ACK_SLOT0)) || (slot == 5'(ACK_SLOT1)) || (slot == 5'(ACK_SLOT2));
  assign q_last = (phase == ST_GAP) ? (q == 2'(GAP_TICKS - 1)) : (q == 2'(TICKS_PER_BIT - 1));
  assign done   = active && tick && (phase == ST_GAP) && q_last;
  assign nack   = fail;

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      active <= 1'b0;
      phase  <= ST_START;
      q      <= 2'd0;
      slot   <= 5'd0;
      sr     <= '0;
      fail   <= 1'b0;
    end else if (go && !active) begin
      active <= 1'b1;
      phase  <= ST_START;
      q      <= 2'd0;
      slot   <= 5'd0;
      sr     <= frame;
      fail   <= 1'b0;
    end else if (active && tick) begin
      q <= q_last ? 2'd0 : q + 2'd1;
      if (phase == ST_BITS && q == 2'd2 && is_ack && sda_in) fail <= 1'b1;
      if (q_last) begin
        case (phase)
          ST_START: phase <= ST_BITS;
          ST_BITS: begin
            if (is_ack && (fail || slot == 5'(FRAME_BITS - 1))) phase <= ST_STOP;
            else begin
              slot <= slot + 5'd1;
              if (!is_ack) sr <= {sr[22:0], 1'b0};
            end
          end
          ST_STOP: phase <= ST_GAP;
          default: active <= 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    scl_d = 1'b1;
    oe_d  = 1'b0;
    if (active) begin
      case (phase)
        ST_START: begin
          scl_d = (q != 2'd3);
          oe_d  = (q != 2'd0);
        end
        ST_BITS: begin
          scl_d = (q == 2'd1) || (q == 2'd2);
          oe_d  = !is_ack && !sr[23];
        end
        ST_STOP: begin
          scl_d = (q != 2'd0);
          oe_d  = (q < 2'd2);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      scl    <= 1'b1;
      sda_oe <= 1'b0;
    end else begin
      scl    <= scl_d;
      sda_oe <= oe_d;
    end
  end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Walks the codec register table, one I2C write per entry, and reports done/error.
// Optional CODEC_CFG_RETRY_EN: a NACKed entry is retried up to MAX_RETRY times before aborting.
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int         CLK_HZ    = 50_000_000,
  parameter int         SCL_HZ    = 100_000,
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         NUM_REGS  = 10,
  parameter int         MAX_RETRY = 3,
  parameter int         TBL_AW    = $clog2(NUM_REGS)
) (
  input  logic              i_CLK,
  input  logic              i_NRESET,
  input  logic              i_START,
  output logic [TBL_AW-1:0] o_TBL_ADDR,
  input  logic [15:0]       i_TBL_DATA,
  output logic              o_SCL,
  output logic              o_SDA_OE,
  input  logic              i_SDA,
  output logic              o_BUSY,
  output logic              o_DONE,
  output logic              o_ERROR,
  output logic [TBL_AW-1:0] o_ERR_INDEX
);

  localparam int DIV = tick_div(CLK_HZ, SCL_HZ);
  localparam int RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`ifdef CODEC_CFG_RETRY_EN
  localparam int RETRY_LIMIT = MAX_RETRY;
`else
  localparam int RETRY_LIMIT = 0;
`endif

  state_t            state;
  logic [TBL_AW-1:0] idx;
  logic [TBL_AW-1:0] err_idx;
  logic [RW-1:0]     retry;
  logic              done_r;
  logic              err_r;
  logic              busy;
  logic              go;
  logic              eng_done;
  logic              eng_nack;

  // ST_START stands for the whole frame in flight; the engine walks START..GAP itself.
  assign busy = (state == ST_LOAD) || (state == ST_START);
  assign go   = (state == ST_LOAD);

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      state   <= ST_IDLE;
      idx     <= '0;
      err_idx <= '0;
      retry   <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: state <= ST_START;
        ST_START: begin
          if (eng_done) begin
            if (!eng_nack) begin
              if (idx == TBL_AW'(NUM_REGS - 1)) begin
                state  <= ST_DONE;
                done_r <= 1'b1;
              end else begin
                idx   <= idx + 1'b1;
                retry <= '0;
                state <= ST_LOAD;
              end
            end else if (retry != RW'(RETRY_LIMIT)) begin
              retry <= retry + 1'b1;
              state <= ST_LOAD;
            end else begin
              state   <= ST_ERR;
              err_r   <= 1'b1;
              err_idx <= idx;
            end
          end
        end
        default: begin
          if (i_START) begin
            state  <= ST_LOAD;
            idx    <= '0;
            retry  <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
          end
        end
      endcase
    end
  end

  i2c_write_engine #(.DIV(DIV)) u_eng (
    .i_CLK    (i_CLK),
    .i_NRESET (i_NRESET),
    .run      (busy),
    .go       (go),
    .frame    ({DEV_ADDR, 1'b0, i_TBL_DATA}),
    .sda_in   (i_SDA),
    .scl      (o_SCL),
    .sda_oe   (o_SDA_OE),
    .done     (eng_done),
    .nack     (eng_nack)
  );

  assign o_TBL_ADDR  = idx;
  assign o_BUSY      = busy;
  assign o_DONE      = done_r;
  assign o_ERROR     = err_r;
  assign o_ERR_INDEX = err_idx;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Bench for codec_cfg_sequencer: I2C slave/bus decoder plus a frame-list model of the whole sequence.
module tb_codec_cfg_sequencer;

  localparam int NUM     = 10;
  localparam int AW      = 4;
  localparam int EXP_LAT = 4800;  // 10 entries * 120 ticks * DIV(4)
`ifdef CODEC_CFG_RETRY_EN
  localparam int LIM = 3;
`else
  localparam int LIM = 0;
`endif

  logic          i_CLK = 1'b0;
  logic          i_NRESET = 1'b0;
  logic          i_START = 1'b0;
  logic [AW-1:0] o_TBL_ADDR;
  logic [15:0]   i_TBL_DATA;
  logic          o_SCL, o_SDA_OE, i_SDA, o_BUSY, o_DONE, o_ERROR;
  logic [AW-1:0] o_ERR_INDEX;

  logic [15:0] tbl [NUM];
  logic        slave_low = 1'b0;

  always #5 i_CLK = ~i_CLK;

  assign i_TBL_DATA = tbl[o_TBL_ADDR];
  assign i_SDA      = ~(o_SDA_OE | slave_low);

  codec_cfg_sequencer #(
    .CLK_HZ(1_600_000), .SCL_HZ(100_000), .DEV_ADDR(7'h1A), .NUM_REGS(NUM), .MAX_RETRY(3)
  ) dut (
    .i_CLK(i_CLK), .i_NRESET(i_NRESET), .i_START(i_START), .o_TBL_ADDR(o_TBL_ADDR),
    .i_TBL_DATA(i_TBL_DATA), .o_SCL(o_SCL), .o_SDA_OE(o_SDA_OE), .i_SDA(i_SDA),
    .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_ERROR(o_ERROR), .o_ERR_INDEX(o_ERR_INDEX)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         nb;
    logic [7:0] b0, b1, b2;
  } frame_t;

  frame_t expq[$];
  frame_t mf;

  // Slave behaviour and expected outcome of the current run
  int   t_ent = -1, t_slot = 1, t_left = 0;
  logic exp_done, exp_err, exp_clean;
  int   exp_idx;
  time  t0;

  // Bus decoder state
  logic       pscl = 1'b1, psda = 1'b1, in_frame = 1'b0;
  int         bitcnt = 0, nb = 0, starts = 0, frames = 0;
  logic [7:0] cur;
  logic [7:0] rb [3];
  logic [6:0] reg7;
  logic       nackit;

  always @(negedge i_CLK) begin
    if (!i_NRESET) begin
      in_frame  = 1'b0;
      slave_low = 1'b0;
      pscl      = 1'b1;
      psda      = 1'b1;
    end else begin
      checks++;
      if ((o_BUSY && (o_DONE || o_ERROR)) || (o_DONE && o_ERROR)) begin
        errors++;
        $display("FAIL status_excl: busy=%b done=%b error=%b, busy/done/error must be exclusive",
                 o_BUSY, o_DONE, o_ERROR);
      end
      if (pscl && o_SCL && psda && !i_SDA) begin
        in_frame = 1'b1; bitcnt = 0; nb = 0; starts++;
      end else if (pscl && o_SCL && !psda && i_SDA) begin
        if (in_frame) begin
          frames++;
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame: got frame with %0d bytes, expected none", nb);
          end else begin
            mf = expq.pop_front();
            chk("frame_nbytes", nb, mf.nb);
            chk("frame_addr", rb[0], mf.b0);
            if (mf.nb > 1 && nb > 1) chk("frame_reg", rb[1], mf.b1);
            if (mf.nb > 2 && nb > 2) chk("frame_data", rb[2], mf.b2);
          end
        end
        in_frame = 1'b0;
      end else if (in_frame && !pscl && o_SCL) begin
        if (bitcnt < 8) begin
          cur = {cur[6:0], i_SDA};
          bitcnt++;
        end else if (bitcnt == 8) begin
          if (nb < 3) rb[nb] = cur;
          nb++;
          bitcnt = 9;
        end
      end else if (in_frame && pscl && !o_SCL) begin
        if (bitcnt == 8) begin
          reg7   = (nb == 1) ? cur[7:1] : rb[1][7:1];
          nackit = (t_ent >= 0) && (nb == t_slot) && (t_left != 0) && (reg7 == tbl[t_ent][15:9]);
          if (nackit && t_left > 0) t_left--;
          slave_low = !nackit;
        end else if (bitcnt == 9) begin
          slave_low = 1'b0;
          bitcnt = 0;
        end
      end
      pscl = o_SCL;
      psda = i_SDA;
    end
  end

  function automatic frame_t mkframe(input int i, input int n);
    frame_t f;
    f.nb = n;
    f.b0 = 8'h34;
    f.b1 = tbl[i][15:8];
    f.b2 = tbl[i][7:0];
    return f;
  endfunction

  // Builds the expected frame list from the table and slave behaviour, then pulses i_START.
  task automatic kick(input int ent, input int slot, input int nacks);
    int  fails;
    expq.delete();
    t_ent = ent; t_slot = slot; t_left = nacks;
    exp_err = 1'b0; exp_idx = 0; exp_clean = 1'b1;
    for (int i = 0; i < NUM; i++) begin
      fails = 0;
      if (i == ent) fails = (nacks < 0 || nacks > LIM) ? LIM + 1 : nacks;
      if (fails > 0) exp_clean = 1'b0;
      for (int k = 0; k < fails; k++) expq.push_back(mkframe(i, slot + 1));
      if (i == ent && (nacks < 0 || nacks > LIM)) begin
        exp_err = 1'b1; exp_idx = i;
        break;
      end
      expq.push_back(mkframe(i, 3));
    end
    exp_done = !exp_err;
    @(negedge i_CLK); i_START = 1'b1;
    @(posedge i_CLK); t0 = $time;
    @(negedge i_CLK); i_START = 1'b0;
    chk("accept_busy", o_BUSY, 1);
    chk("accept_done_clr", o_DONE, 0);
    chk("accept_err_clr", o_ERROR, 0);
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    int lat;
    while (!(o_DONE || o_ERROR) && n < 20000) begin
      @(negedge i_CLK); n++;
    end
    if (n >= 20000) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no done/error after %0d cycles", tag, n);
    end
    chk({tag, "_done"}, o_DONE, exp_done);
    chk({tag, "_error"}, o_ERROR, exp_err);
    chk({tag, "_busy"}, o_BUSY, 0);
    if (exp_err) chk({tag, "_err_index"}, o_ERR_INDEX, exp_idx);
    if (exp_clean) begin
      lat = int'(($time - t0 - 5) / 10);
      checks++;
      if (lat < EXP_LAT - 2 || lat > EXP_LAT + 2) begin
        errors++;
        $display("FAIL %s_latency: got %0d cycles expected %0d +/-2", tag, lat, EXP_LAT);
      end
    end
    chk({tag, "_frames_left"}, expq.size(), 0);
  endtask

  initial begin
    int base, f0, s0, n, ent, slot, nk;
    base = int'($urandom_range(0, 127));
    for (int i = 0; i < NUM; i++) tbl[i] = {7'(base + i * 13), 9'($urandom)};

    #12;
    chk("rst_scl", o_SCL, 1);
    chk("rst_sda_oe", o_SDA_OE, 0);
    chk("rst_busy", o_BUSY, 0);
    chk("rst_done", o_DONE, 0);
    chk("rst_error", o_ERROR, 0);
    chk("rst_tbl_addr", o_TBL_ADDR, 0);
    @(negedge i_CLK); #2 i_NRESET = 1'b1;
    repeat (3) @(negedge i_CLK);

    // All entries ACKed
    f0 = frames;
    kick(-1, 1, 0);
    wait_end("pass");
    chk("pass_frames", frames - f0, 10);

    // Entry 3 NACKs its register byte forever
    f0 = frames;
    kick(3, 1, -1);
    wait_end("nack3");
    chk("nack3_frames", frames - f0, 3 + LIM + 1);
    s0 = starts;
    repeat (1000) @(negedge i_CLK);
    chk("nack3_no_restart", starts, s0);

    // Entry 3 NACKs its data byte twice, then ACKs
    kick(3, 2, 2);
    wait_end("nack3x2");

    for (int r = 0; r < 3; r++) begin
      ent  = int'($urandom_range(0, NUM - 1));
      slot = int'($urandom_range(1, 2));
      nk   = int'($urandom_range(0, 5)) - 1;
      kick(ent, slot, nk);
      wait_end("rand");
    end

    // Asynchronous reset in the middle of entry 2's register byte
    f0 = frames;
    kick(-1, 1, 0);
    n = 0;
    while (!(frames == f0 + 2 && in_frame && nb == 1 && bitcnt == 4) && n < 20000) begin
      @(negedge i_CLK); n++;
    end
    if (n >= 20000) begin
      checks++; errors++;
      $display("FAIL midreset_wait: entry 2 byte never reached after %0d cycles", n);
    end
    #2 i_NRESET = 1'b0;
    #1;
    chk("midrst_scl", o_SCL, 1);
    chk("midrst_sda_oe", o_SDA_OE, 0);
    chk("midrst_busy", o_BUSY, 0);
    chk("midrst_done", o_DONE, 0);
    chk("midrst_error", o_ERROR, 0);
    chk("midrst_tbl_addr", o_TBL_ADDR, 0);
    chk("midrst_err_index", o_ERR_INDEX, 0);
    repeat (3) @(negedge i_CLK);
    #2 i_NRESET = 1'b1;
    repeat (2) @(negedge i_CLK);
    f0 = frames;
    kick(-1, 1, 0);
    wait_end("after_rst");
    chk("after_rst_frames", frames - f0, 10);

    // Stray i_START while busy, then restart from DONE
    f0 = frames;
    kick(-1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      repeat (200 + int'($urandom_range(0, 500))) @(negedge i_CLK);
      i_START = 1'b1;
      @(negedge i_CLK);
      i_START = 1'b0;
    end
    wait_end("busy_start");
    chk("busy_start_frames", frames - f0, 10);
    f0 = frames;
    kick(-1, 1, 0);
    wait_end("repeat");
    chk("repeat_frames", frames - f0, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
